// File: rtl/clahe_hist_ram_ctrl.sv
// Histogram BRAM sequencer for one CLAHE tile: clear sweep, forwarded read-modify-write
// bin accumulation, and a sequential readout stream with optional clear-behind-read.
module clahe_hist_ram_ctrl #(
  parameter int BIN_W         = 8,
  parameter int CNT_W         = 16,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             pix_valid,
  input  logic [BIN_W-1:0] pix_bin,
  input  logic             rd_start,
  output logic             ram_re,
  output logic [BIN_W-1:0] ram_raddr,
  input  logic [CNT_W-1:0] ram_rdata,
  output logic             ram_we,
  output logic [BIN_W-1:0] ram_waddr,
  output logic [CNT_W-1:0] ram_wdata,
  output logic             ready,
  output logic             hist_done,
  output logic             rd_valid,
  output logic [BIN_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_last,
  output logic             sat_flag
);

  localparam logic [BIN_W-1:0] LAST_BIN = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    ACCUM   = 3'd2,
    DRAIN   = 3'd3,
    READOUT = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [BIN_W-1:0] cnt, cnt_next;
  logic             sweep_done, sweep_done_next;
  logic [1:0]       drain_cnt, drain_cnt_next;
  logic             clear_wr, accept, ro_issue, drain_end, sat_clr;

  logic             s1_valid, s2_valid;
  logic [BIN_W-1:0] s2_bin;
  logic             ro1_valid, ro2_valid;
  logic [BIN_W-1:0] ro2_bin;
  logic             w2_valid;
  logic [BIN_W-1:0] w2_addr;
  logic [CNT_W-1:0] w2_data;
  logic [CNT_W-1:0] src, sum;
  logic             sat_hit;

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= CLEAR;
      cnt        <= '0;
      sweep_done <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sweep_done <= sweep_done_next;
      drain_cnt  <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    sweep_done_next = sweep_done;
    drain_cnt_next  = drain_cnt;
    clear_wr        = 1'b0;
    accept          = 1'b0;
    ro_issue        = 1'b0;
    drain_end       = 1'b0;
    sat_clr         = 1'b0;
    case (state)
      CLEAR: begin
        clear_wr = 1'b1;
        cnt_next = cnt + BIN_W'(1);
        if (cnt == LAST_BIN) state_next = IDLE;
      end
      IDLE: begin
        cnt_next        = '0;
        sweep_done_next = 1'b0;
        drain_cnt_next  = '0;
        if (frame_start) begin
          state_next = ACCUM;
          sat_clr    = 1'b1;
        end else if (rd_start) begin
          state_next = READOUT;
        end
      end
      ACCUM: begin
        accept = pix_valid;
        if (frame_end) state_next = DRAIN;
      end
      DRAIN: begin
        drain_cnt_next = drain_cnt + 2'd1;
        if (drain_cnt == 2'd3) begin
          drain_end  = 1'b1;
          state_next = IDLE;
        end
      end
      READOUT: begin
        if (!sweep_done) begin
          ro_issue = 1'b1;
          cnt_next = cnt + BIN_W'(1);
          if (cnt == LAST_BIN) sweep_done_next = 1'b1;
        end
        if (ro2_valid && ro2_bin == LAST_BIN) state_next = IDLE;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Newest in-flight write wins so back-to-back hits on one bin never see stale RAM data.
  always_comb begin
    if (ram_we && ram_waddr == s2_bin)        src = ram_wdata;
    else if (w2_valid && w2_addr == s2_bin)   src = w2_data;
    else                                      src = ram_rdata;
    sat_hit = s2_valid && (src == CNT_MAX);
    sum     = (src == CNT_MAX) ? src : src + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_re    <= 1'b0;
      ram_raddr <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_bin    <= '0;
      ro1_valid <= 1'b0;
      ro2_valid <= 1'b0;
      ro2_bin   <= '0;
      w2_valid  <= 1'b0;
      w2_addr   <= '0;
      w2_data   <= '0;
      rd_valid  <= 1'b0;
      rd_bin    <= '0;
      rd_count  <= '0;
      rd_last   <= 1'b0;
      hist_done <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      ram_re <= accept | ro_issue;
      if (accept)        ram_raddr <= pix_bin;
      else if (ro_issue) ram_raddr <= cnt;

      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      s2_bin    <= ram_raddr;
      ro1_valid <= ro_issue;
      ro2_valid <= ro1_valid;
      ro2_bin   <= ram_raddr;

      if (clear_wr) begin
        ram_we    <= 1'b1;
        ram_waddr <= cnt;
        ram_wdata <= '0;
      end else if (s2_valid) begin
        ram_we    <= 1'b1;
        ram_waddr <= s2_bin;
        ram_wdata <= sum;
      end else if (CLEAR_ON_READ && ro1_valid) begin
        ram_we    <= 1'b1;
        ram_waddr <= ram_raddr;
        ram_wdata <= '0;
      end else begin
        ram_we    <= 1'b0;
      end

      w2_valid <= ram_we;
      w2_addr  <= ram_waddr;
      w2_data  <= ram_wdata;

      rd_valid  <= ro2_valid;
      rd_bin    <= ro2_bin;
      rd_count  <= ro2_valid ? ram_rdata : '0;
      rd_last   <= ro2_valid && (ro2_bin == LAST_BIN);
      hist_done <= drain_end;

      if (sat_clr)      sat_flag <= 1'b0;
      else if (sat_hit) sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clahe_hist_ram_ctrl.sv
// Scoreboard bench for clahe_hist_ram_ctrl: one instance clearing on read, one keeping its
// contents, each with a behavioural 1-cycle, old-data-on-collision RAM.
module tb_clahe_hist_ram_ctrl;

  localparam int BW = 4;
  localparam int CW = 8;
  localparam int NB = 16;

  typedef logic [CW-1:0] hist_t [NB];
  typedef struct {
    logic [BW-1:0] bin;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0, rd_start = 1'b0;
  logic [BW-1:0] pix_bin = '0;
  logic en_a = 1'b1, en_k = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  exp_t qa[$];
  exp_t qk[$];
  exp_t wa, wk;

  always #5 clk = ~clk;

  logic          a_ram_re, a_ram_we, a_ready, a_hist_done, a_rd_valid, a_rd_last, a_sat_flag;
  logic [BW-1:0] a_ram_raddr, a_ram_waddr, a_rd_bin;
  logic [CW-1:0] a_ram_wdata, a_rd_count;
  logic [CW-1:0] a_ram_rdata = '0;
  logic          k_ram_re, k_ram_we, k_ready, k_hist_done, k_rd_valid, k_rd_last, k_sat_flag;
  logic [BW-1:0] k_ram_raddr, k_ram_waddr, k_rd_bin;
  logic [CW-1:0] k_ram_wdata, k_rd_count;
  logic [CW-1:0] k_ram_rdata = '0;

  logic [CW-1:0] mem_a [NB] = '{default: 8'hA5};
  logic [CW-1:0] mem_k [NB] = '{default: 8'h5A};

  clahe_hist_ram_ctrl #(.BIN_W(BW), .CNT_W(CW), .CLEAR_ON_READ(1'b1)) dut_a (
    .clk(clk), .rstn(rstn),
    .frame_start(frame_start & en_a), .frame_end(frame_end & en_a),
    .pix_valid(pix_valid & en_a), .pix_bin(pix_bin), .rd_start(rd_start & en_a),
    .ram_re(a_ram_re), .ram_raddr(a_ram_raddr), .ram_rdata(a_ram_rdata),
    .ram_we(a_ram_we), .ram_waddr(a_ram_waddr), .ram_wdata(a_ram_wdata),
    .ready(a_ready), .hist_done(a_hist_done), .rd_valid(a_rd_valid), .rd_bin(a_rd_bin),
    .rd_count(a_rd_count), .rd_last(a_rd_last), .sat_flag(a_sat_flag));

  clahe_hist_ram_ctrl #(.BIN_W(BW), .CNT_W(CW), .CLEAR_ON_READ(1'b0)) dut_k (
    .clk(clk), .rstn(rstn),
    .frame_start(frame_start & en_k), .frame_end(frame_end & en_k),
    .pix_valid(pix_valid & en_k), .pix_bin(pix_bin), .rd_start(rd_start & en_k),
    .ram_re(k_ram_re), .ram_raddr(k_ram_raddr), .ram_rdata(k_ram_rdata),
    .ram_we(k_ram_we), .ram_waddr(k_ram_waddr), .ram_wdata(k_ram_wdata),
    .ready(k_ready), .hist_done(k_hist_done), .rd_valid(k_rd_valid), .rd_bin(k_rd_bin),
    .rd_count(k_rd_count), .rd_last(k_rd_last), .sat_flag(k_sat_flag));

  always @(posedge clk) begin
    if (a_ram_re) a_ram_rdata <= mem_a[a_ram_raddr];
    if (a_ram_we) mem_a[a_ram_waddr] <= a_ram_wdata;
    if (k_ram_re) k_ram_rdata <= mem_k[k_ram_raddr];
    if (k_ram_we) mem_k[k_ram_waddr] <= k_ram_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_word(input string tag, input exp_t e, input logic [BW-1:0] bin,
                              input logic [CW-1:0] cnt, input logic last);
    check_output($sformatf("%s_rd_bin", tag), 32'(bin), 32'(e.bin));
    check_output($sformatf("%s_rd_count[%0d]", tag, e.bin), 32'(cnt), 32'(e.cnt));
    check_output($sformatf("%s_rd_last[%0d]", tag, e.bin), 32'(last), 32'(e.last));
  endtask

  task automatic unexpected_word(input string tag, input logic [BW-1:0] bin);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s_unexpected_word: got rd_valid on bin %0d expected no word", tag, bin);
  endtask

  // Monitor: every readout word the DUTs present is matched against the queued expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (a_rd_valid) begin
        if (qa.size() == 0) unexpected_word("a", a_rd_bin);
        else begin
          wa = qa.pop_front();
          compare_word("a", wa, a_rd_bin, a_rd_count, a_rd_last);
        end
      end
      if (k_rd_valid) begin
        if (qk.size() == 0) unexpected_word("k", k_rd_bin);
        else begin
          wk = qk.pop_front();
          compare_word("k", wk, k_rd_bin, k_rd_count, k_rd_last);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (n < 60 && !(a_ready && k_ready)) begin
      tick;
      n++;
    end
    check_output({name, "_ready"}, 32'(a_ready && k_ready), 1);
  endtask

  task automatic wait_done(input string name);
    int lat = 0;
    while (lat < 20 && !a_hist_done) begin
      tick;
      lat++;
    end
    check_output({name, "_hist_done_latency"}, lat, 4);
    tick;
    check_output({name, "_hist_done_pulse"}, 32'(a_hist_done), 0);
  endtask

  task automatic apply_stimulus(input int pix[$], input bit end_with_last, input string name);
    wait_ready(name);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    foreach (pix[i]) begin
      pix_valid = (pix[i] >= 0);
      pix_bin   = pix[i][BW-1:0];
      frame_end = end_with_last && (i == pix.size() - 1);
      tick;
    end
    pix_valid = 1'b0;
    frame_end = 1'b0;
    if (!end_with_last || pix.size() == 0) begin
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
    end
    wait_done(name);
  endtask

  task automatic push_expected(input hist_t ea, input hist_t ek);
    for (int i = 0; i < NB; i++) begin
      if (en_a) qa.push_back('{bin: BW'(i), cnt: ea[i], last: (i == NB - 1)});
      if (en_k) qk.push_back('{bin: BW'(i), cnt: ek[i], last: (i == NB - 1)});
    end
  endtask

  task automatic readout(input hist_t ea, input hist_t ek, input string name);
    int n = 0;
    wait_ready(name);
    push_expected(ea, ek);
    rd_start = 1'b1;
    tick;
    rd_start = 1'b0;
    while (n < 60 && !(qa.size() == 0 && qk.size() == 0 && a_ready && k_ready)) begin
      tick;
      n++;
    end
    check_output({name, "_words_left"}, 32'(qa.size() + qk.size()), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_ctl"}, 32'({a_ram_re, a_ram_we, a_ready, a_hist_done, a_rd_valid,
                                      a_rd_last, a_sat_flag}), 0);
    check_output({name, "_bus"}, 32'({a_ram_raddr, a_ram_waddr, a_ram_wdata, a_rd_bin, a_rd_count}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hist_t z, h;
    hist_t h2;
    int p[$];
    int cyc;

    z = '{default: '0};

    // Reset state, then the clear sweep length.
    repeat (3) tick;
    check_reset_outputs("reset");
    rstn = 1'b1;
    cyc = 0;
    while (!a_ready && cyc < 40) begin
      tick;
      cyc++;
    end
    check_output("ready_latency", cyc, 16);

    en_k = 1'b1;
    readout(z, z, "t1");
    en_k = 1'b0;

    // Five hits on one bin, last one alongside frame_end.
    p = {3, 3, 3, 3, 3};
    apply_stimulus(p, 1'b1, "t2");
    h = z; h[3] = 8'd5;
    readout(h, z, "t2");

    p = {3, 7, 3, 7, 3, 3, -1, 3};
    apply_stimulus(p, 1'b0, "t3");
    check_output("t3_sat_flag", 32'(a_sat_flag), 0);
    h = z; h[3] = 8'd5; h[7] = 8'd2;
    readout(h, z, "t3");

    p = {9, -1, -1, 9, 9};
    apply_stimulus(p, 1'b0, "t3b");
    h = z; h[9] = 8'd3;
    readout(h, z, "t3b");

    // Saturation and its sticky flag.
    p.delete();
    for (int i = 0; i < 300; i++) p.push_back(0);
    apply_stimulus(p, 1'b0, "t4");
    check_output("t4_sat_flag_set", 32'(a_sat_flag), 1);
    h = z; h[0] = 8'd255;
    readout(h, z, "t4");
    check_output("t4_sat_flag_sticky", 32'(a_sat_flag), 1);
    wait_ready("t4b");
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check_output("t4_sat_flag_cleared", 32'(a_sat_flag), 0);
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    wait_done("t4b");

    // Clear-on-read versus keep-contents.
    en_k = 1'b1;
    p = {1, 2, 2, 15, 15, 15};
    apply_stimulus(p, 1'b0, "t5");
    h = z; h[1] = 8'd1; h[2] = 8'd2; h[15] = 8'd3;
    readout(h, h, "t5_first");
    readout(z, h, "t5_second");
    p = {2};
    apply_stimulus(p, 1'b0, "t5_acc");
    h2 = z; h2[2] = 8'd1;
    h[2] = 8'd3;
    readout(h2, h, "t5_third");

    // Reset mid-ACCUM.
    wait_ready("t6a");
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    pix_valid = 1'b1;
    pix_bin = 4'd4;
    repeat (3) tick;
    rstn = 1'b0;
    pix_valid = 1'b0;
    #1;
    check_reset_outputs("t6_reset_accum");
    tick;
    tick;
    rstn = 1'b1;
    readout(z, z, "t6a");

    // Reset mid-READOUT.
    wait_ready("t6b");
    push_expected(z, z);
    rd_start = 1'b1;
    tick;
    rd_start = 1'b0;
    repeat (5) tick;
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_reset_readout");
    qa.delete();
    qk.delete();
    tick;
    tick;
    rstn = 1'b1;
    wait_ready("t6b_clear");

    // Pixels offered while idle must not land in any bin.
    pix_valid = 1'b1;
    pix_bin = 4'd6;
    repeat (4) tick;
    pix_valid = 1'b0;
    readout(z, z, "t6c");

    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
